// File: rtl/ser_tx_sched.sv
// Serial-line transmit scheduler: byte FIFO drained onto the serial port register
// pair, with a status poll before every write and bit-rate changes only between frames.
module ser_tx_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GUARD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr,
  input  logic          set_rate,
  input  logic [2:0]    rate,
  output logic          busy,
  output logic          ser_stb,
  output logic          ser_we,
  output logic          ser_addr,
  output logic [31:0]   ser_dout,
  input  logic [31:0]   ser_din,
  input  logic          ser_ack
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_POLL, S_WRITE, S_RATE, S_GUARD} state_t;

  state_t                 state, state_n;
  logic                   tgt_rate, tgt_rate_n;
  logic [GW-1:0]          gcnt, gcnt_n;
  logic [DEPTH-1:0][7:0]  mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   pend;
  logic [2:0]             rate_pend, rate_nx;
  logic                   push_ok, pop, tx_rdy;
  logic                   stb_n, we_n, addr_n;
  logic [31:0]            dout_n;
  logic                   unused_din;

  assign full       = (level == (AW+1)'(DEPTH));
  assign push_ok    = push & ~full;
  assign pop        = (state == S_WRITE) & ser_ack;
  assign tx_rdy     = ser_din[1];
  assign unused_din = ^{ser_din[31:2], ser_din[0]};
  // A set_rate in the cycle we enter RATE must be the code that goes out.
  assign rate_nx    = set_rate ? rate : rate_pend;
  assign busy       = (state != S_IDLE) | (level != '0) | pend;

  always_comb begin
    state_n    = state;
    tgt_rate_n = tgt_rate;
    gcnt_n     = gcnt;
    case (state)
      S_IDLE: begin
        if (pend) begin
          tgt_rate_n = 1'b1;
          state_n    = S_POLL;
        end else if (level != '0) begin
          tgt_rate_n = 1'b0;
          state_n    = S_POLL;
        end
      end
      S_POLL:  if (ser_ack && tx_rdy) state_n = tgt_rate ? S_RATE : S_WRITE;
      S_WRITE: if (ser_ack) begin
        state_n = S_GUARD;
        gcnt_n  = GW'(GUARD - 1);
      end
      S_RATE:  if (ser_ack) state_n = S_IDLE;
      S_GUARD: begin
        if (gcnt == '0) state_n = S_IDLE;
        else            gcnt_n  = gcnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered.
  always_comb begin
    stb_n  = 1'b0;
    we_n   = 1'b0;
    addr_n = 1'b0;
    dout_n = '0;
    case (state_n)
      S_POLL: begin
        stb_n  = 1'b1;
        addr_n = 1'b1;
      end
      S_WRITE: begin
        stb_n  = 1'b1;
        we_n   = 1'b1;
        dout_n = {24'b0, mem[rd_ptr]};
      end
      S_RATE: begin
        stb_n  = 1'b1;
        we_n   = 1'b1;
        addr_n = 1'b1;
        dout_n = {29'b0, rate_nx};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tgt_rate  <= 1'b0;
      gcnt      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      pend      <= 1'b0;
      rate_pend <= '0;
      ser_stb   <= 1'b0;
      ser_we    <= 1'b0;
      ser_addr  <= 1'b0;
      ser_dout  <= '0;
    end else begin
      state    <= state_n;
      tgt_rate <= tgt_rate_n;
      gcnt     <= gcnt_n;
      ser_stb  <= stb_n;
      ser_we   <= we_n;
      ser_addr <= addr_n;
      ser_dout <= dout_n;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
      // Overflow beats a simultaneous clear.
      if (push && full) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (set_rate) begin
        pend      <= 1'b1;
        rate_pend <= rate;
      end else if (state == S_RATE && ser_ack) begin
        pend <= 1'b0;
      end
    end
  end

endmodule
